// File: rtl/branch_ctrl.sv
// Branch resolution unit: evaluates a condition on the {Z,V,N} flag register,
// redirects the PC on a taken branch and holds flush for FLUSH_CYCLES cycles.
module branch_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              z,
    input  logic              v,
    input  logic              n,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              flush,
    output logic [2:0]        flags,
    input  logic              cnt_clr,
    output logic [15:0]       br_count,
    output logic [15:0]       taken_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic              pc_load_q, pc_load_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              flush_q, flush_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [2:0]        flags_q, flags_d;
    logic [15:0]       br_count_q, br_count_d;
    logic [15:0]       taken_count_q, taken_count_d;

    logic cond_true;
    logic hs;
    logic taken;
    logic unused_cond_msb;

    assign unused_cond_msb = br_cond[3];

    // Condition is evaluated on the registered flags, not on the ALU inputs.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond[2:0])
            3'd0: cond_true = flags_q[2];
            3'd1: cond_true = flags_q[0] & ~flags_q[1];
            3'd2: cond_true = ~flags_q[2] & ~flags_q[1] & ~flags_q[0];
            3'd3: cond_true = flags_q[1];
            3'd4: cond_true = ~flags_q[2];
            3'd5: cond_true = flags_q[1] | ~flags_q[0];
            3'd6: cond_true = (flags_q[0] & ~flags_q[1]) | flags_q[2];
            default: cond_true = 1'b1;
        endcase
    end

    assign br_ready = (state_q == IDLE) && !flag_we;
    assign hs       = br_valid && br_ready;
    assign taken    = hs && cond_true;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (taken) state_d = FLUSH;
            FLUSH:   if (fcnt_q == 3'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_load_d = 1'b0;
        pc_next_d = pc_next_q;
        flush_d   = 1'b0;
        fcnt_d    = fcnt_q;
        case (state_q)
            IDLE: begin
                if (taken) begin
                    pc_load_d = 1'b1;
                    pc_next_d = br_target;
                    flush_d   = 1'b1;
                    fcnt_d    = FLUSH_LAST;
                end
            end
            FLUSH: begin
                if (fcnt_q != 3'd0) begin
                    flush_d = 1'b1;
                    fcnt_d  = fcnt_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    // A flag write during flush belongs to a squashed instruction.
    always_comb begin
        flags_d = flags_q;
        if (flag_we && !flush_q) begin
            flags_d = {z, v, n};
        end
    end

    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (cnt_clr) begin
            br_count_d    = 16'd0;
            taken_count_d = 16'd0;
        end else begin
            if (hs && br_count_q != 16'hFFFF) begin
                br_count_d = br_count_q + 16'd1;
            end
            if (taken && taken_count_q != 16'hFFFF) begin
                taken_count_d = taken_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_load_q     <= 1'b0;
            pc_next_q     <= '0;
            flush_q       <= 1'b0;
            fcnt_q        <= 3'd0;
            flags_q       <= 3'd0;
            br_count_q    <= 16'd0;
            taken_count_q <= 16'd0;
        end else begin
            pc_load_q     <= pc_load_d;
            pc_next_q     <= pc_next_d;
            flush_q       <= flush_d;
            fcnt_q        <= fcnt_d;
            flags_q       <= flags_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign pc_load     = pc_load_q;
    assign pc_next     = pc_next_q;
    assign flush       = flush_q;
    assign flags       = flags_q;
    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_we;
    logic        z, v, n;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [15:0] br_target;
    logic        br_ready;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        flush;
    logic [2:0]  flags;
    logic        cnt_clr;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    int total = 0;
    int bad   = 0;

    // taken_mask[c][f]: hand-derived taken result for cond c with flags f={Z,V,N}
    logic [7:0] taken_mask [8];

    branch_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .z(z), .v(v), .n(n),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .br_ready(br_ready), .pc_load(pc_load), .pc_next(pc_next),
        .flush(flush), .flags(flags), .cnt_clr(cnt_clr),
        .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [2:0] f);
        flag_we = 1'b1;
        {z, v, n} = f;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        taken_mask[0] = 8'hF0;
        taken_mask[1] = 8'h22;
        taken_mask[2] = 8'h01;
        taken_mask[3] = 8'hCC;
        taken_mask[4] = 8'h0F;
        taken_mask[5] = 8'hDD;
        taken_mask[6] = 8'hF2;
        taken_mask[7] = 8'hFF;

        rst = 1'b1; flag_we = 1'b0; z = 1'b0; v = 1'b0; n = 1'b0;
        br_valid = 1'b0; br_cond = 4'd0; br_target = 16'd0; cnt_clr = 1'b0;
        tick(); tick();
        check_eq("rst_flags", 32'(flags), 32'h0);
        check_eq("rst_pc_load", 32'(pc_load), 32'h0);
        check_eq("rst_pc_next", 32'(pc_next), 32'h0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_counts", {br_count, taken_count}, 32'h0);
        rst = 1'b0;
        tick();
        check_eq("idle_ready", 32'(br_ready), 32'h1);

        // Stall: flag write and EQ branch in the same cycle
        flag_we = 1'b1; z = 1'b1; v = 1'b0; n = 1'b0;
        br_valid = 1'b1; br_cond = 4'd0; br_target = 16'h1234;
        #1;
        check_eq("stall_ready", 32'(br_ready), 32'h0);
        tick();
        flag_we = 1'b0; z = 1'b0;
        #1;
        check_eq("stall_flags", 32'(flags), 32'h4);
        check_eq("stall_ready2", 32'(br_ready), 32'h1);
        tick();
        br_valid = 1'b0;
        check_eq("stall_pc_load", 32'(pc_load), 32'h1);
        check_eq("stall_pc_next", 32'(pc_next), 32'h1234);
        check_eq("stall_flush1", 32'(flush), 32'h1);
        check_eq("stall_ready_fl", 32'(br_ready), 32'h0);
        tick();
        check_eq("stall_pc_load2", 32'(pc_load), 32'h0);
        check_eq("stall_flush2", 32'(flush), 32'h1);
        tick();
        check_eq("stall_flush_end", 32'(flush), 32'h0);
        check_eq("stall_counts", {br_count, taken_count}, {16'd1, 16'd1});

        // Not taken: flags=100, NE
        clear_counters();
        br_valid = 1'b1; br_cond = 4'd4; br_target = 16'h0040;
        #1;
        check_eq("nt_ready", 32'(br_ready), 32'h1);
        tick();
        br_valid = 1'b0;
        check_eq("nt_pc_load", 32'(pc_load), 32'h0);
        check_eq("nt_flush", 32'(flush), 32'h0);
        check_eq("nt_pc_next_hold", 32'(pc_next), 32'h1234);
        check_eq("nt_counts", {br_count, taken_count}, {16'd1, 16'd0});

        // Back-to-back: taken A then B waiting
        clear_counters();
        br_valid = 1'b1; br_cond = 4'd7; br_target = 16'h0100;
        tick();
        br_target = 16'h0200;
        check_eq("b2b_pc_next_a", 32'(pc_next), 32'h0100);
        check_eq("b2b_ready_c1", 32'(br_ready), 32'h0);
        tick();
        check_eq("b2b_ready_c2", 32'(br_ready), 32'h0);
        tick();
        check_eq("b2b_ready_c3", 32'(br_ready), 32'h1);
        tick();
        br_valid = 1'b0;
        check_eq("b2b_pc_next_b", 32'(pc_next), 32'h0200);
        check_eq("b2b_pc_load_b", 32'(pc_load), 32'h1);
        check_eq("b2b_br_count", 32'(br_count), 32'd2);
        tick(); tick();

        // Squash: flag writes during flush are dropped
        br_valid = 1'b1; br_cond = 4'd7; br_target = 16'h0300;
        tick();
        br_valid = 1'b0;
        flag_we = 1'b1; z = 1'b0; v = 1'b1; n = 1'b1;
        tick(); tick();
        flag_we = 1'b0;
        check_eq("squash_flush_end", 32'(flush), 32'h0);
        check_eq("squash_flags", 32'(flags), 32'h4);

        // Condition sweep, 8 flag values x 8 conditions
        clear_counters();
        for (int f = 0; f < 8; f++) begin
            load_flags(3'(f));
            for (int c = 0; c < 8; c++) begin
                logic [7:0] m;
                logic       exp_t;
                m = taken_mask[c];
                exp_t = m[f];
                br_valid = 1'b1; br_cond = 4'(c); br_target = 16'(16'h1000 + f * 8 + c);
                tick();
                br_valid = 1'b0;
                check_eq($sformatf("sweep_c%0d_f%0d", c, f), 32'(pc_load), 32'(exp_t));
                if (exp_t) begin
                    tick(); tick();
                end
            end
        end
        check_eq("sweep_br_count", 32'(br_count), 32'd64);
        check_eq("sweep_taken_count", 32'(taken_count), 32'd34);

        // Reset in the first flush cycle
        br_valid = 1'b1; br_cond = 4'd7; br_target = 16'h0ABC;
        tick();
        br_valid = 1'b0;
        check_eq("rstfl_flush_pre", 32'(flush), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("rstfl_flush", 32'(flush), 32'h0);
        check_eq("rstfl_pc_load", 32'(pc_load), 32'h0);
        check_eq("rstfl_counts", {br_count, taken_count}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rstfl_ready", 32'(br_ready), 32'h1);
        tick();

        // cnt_clr wins over a simultaneous handshake
        br_valid = 1'b1; br_cond = 4'd7; br_target = 16'h0055;
        tick();
        br_valid = 1'b0;
        tick(); tick();
        check_eq("clr_pre", {br_count, taken_count}, {16'd1, 16'd1});
        br_valid = 1'b1; cnt_clr = 1'b1;
        tick();
        br_valid = 1'b0; cnt_clr = 1'b0;
        check_eq("clr_counts", {br_count, taken_count}, 32'h0);
        check_eq("clr_pc_load", 32'(pc_load), 32'h1);
        tick(); tick();

        // br_count saturation with not-taken EQ branches (flags=000)
        clear_counters();
        br_valid = 1'b1; br_cond = 4'd0;
        repeat (65534) tick();
        check_eq("sat_fffe", 32'(br_count), 32'hFFFE);
        tick();
        check_eq("sat_ffff", 32'(br_count), 32'hFFFF);
        tick();
        check_eq("sat_hold", 32'(br_count), 32'hFFFF);
        check_eq("sat_taken", 32'(taken_count), 32'h0);
        br_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
